// File: rtl/seg7_scan2_if.sv
// Digit/segment bus between the BCD counter and the two-digit scan driver.
// load is a one-cycle capture strobe with no back-pressure: every cycle with
// load=1 samples dig0/dig1 into the pending pair, and the sink is always ready.
// swg/an0/an1/frame are registered outputs of the driver, active-low where noted.
interface seg7_scan2_if;
    logic [3:0] dig0;   // ones digit, BCD
    logic [3:0] dig1;   // tens digit, BCD
    logic       load;   // capture strobe
    logic [6:0] swg;    // segments g..a, active-low
    logic       an0;    // ones anode, active-low
    logic       an1;    // tens anode, active-low
    logic       frame;  // one-cycle pulse on ones-slot entry

    modport master (
        output dig0, dig1, load,
        input  swg, an0, an1, frame
    );

    modport slave (
        input  dig0, dig1, load,
        output swg, an0, an1, frame
    );
endinterface

// File: rtl/seg7_scan2.sv
// Two-digit time-multiplexed 7-segment driver. Digits are double-buffered
// (pending -> display at frame start) so a frame never shows a torn value.
// Each digit slot is followed by an all-dark gap to suppress ghosting.
module seg7_scan2 #(
    parameter int REFRESH_DIV  = 20000,
    parameter int BLANK_CYCLES = 2,
    parameter bit LZB          = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan2_if.slave bus,
    output logic [1:0]  dbg_state
);

    localparam int MAXLEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam logic [CW-1:0] ON_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        D0_ON = 2'd0,
        GAP0  = 2'd1,
        D1_ON = 2'd2,
        GAP1  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          slot_end;
    logic          enter_frame;

    logic [3:0] p0, p1;   // pending digits
    logic [3:0] q0, q1;   // digits shown in the current frame
    logic [3:0] q0_view;

    logic [6:0] swg_n;
    logic       an0_n, an1_n, frame_n;

    // Active-low segment decode, g..a; non-BCD codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign dbg_state = state;

    // FSM state and slot counter register; reset restarts the scan from GAP1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= GAP1;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Slot sequencing: leave a state when its counter reaches length-1.
    always_comb begin
        state_n  = state;
        slot_end = 1'b0;
        case (state)
            D0_ON, D1_ON: slot_end = (cnt == ON_LAST);
            default:      slot_end = (cnt == GAP_LAST);
        endcase
        if (slot_end) begin
            case (state)
                D0_ON:   state_n = GAP0;
                GAP0:    state_n = D1_ON;
                D1_ON:   state_n = GAP1;
                default: state_n = D0_ON;
            endcase
        end
        cnt_n       = slot_end ? '0 : cnt + 1'b1;
        enter_frame = slot_end && (state == GAP1);
    end

    // Next output values follow the state being entered. On the frame-entry
    // edge the display pair is being loaded from the pending pair, so the
    // ones digit is taken from the pending register for that one cycle.
    always_comb begin
        swg_n   = 7'h7F;
        an0_n   = 1'b1;
        an1_n   = 1'b1;
        frame_n = enter_frame;
        q0_view = enter_frame ? p0 : q0;
        case (state_n)
            D0_ON: begin
                an0_n = 1'b0;
                swg_n = seg_decode(q0_view);
            end
            D1_ON: begin
                if (!(LZB && (q1 == 4'd0))) begin
                    an1_n = 1'b0;
                    swg_n = seg_decode(q1);
                end
            end
            default: ;
        endcase
    end

    // Digit buffers: pending follows LOAD, display copies pending at frame entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0 <= 4'd0;
            p1 <= 4'd0;
            q0 <= 4'd0;
            q1 <= 4'd0;
        end else begin
            if (enter_frame) begin
                q0 <= p0;
                q1 <= p1;
            end
            if (bus.load) begin
                p0 <= bus.dig0;
                p1 <= bus.dig1;
            end
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.swg   <= 7'h7F;
            bus.an0   <= 1'b1;
            bus.an1   <= 1'b1;
            bus.frame <= 1'b0;
        end else begin
            bus.swg   <= swg_n;
            bus.an0   <= an0_n;
            bus.an1   <= an1_n;
            bus.frame <= frame_n;
        end
    end

endmodule

// File: tb/tb_seg7_scan2.sv
// Bench for seg7_scan2: two instances (leading-zero blanking off and on) get
// identical random stimulus and are compared every cycle against a model that
// derives the scan position from elapsed cycles since reset release.
module tb_seg7_scan2;

    localparam int RD = 4;
    localparam int BC = 2;
    localparam int FR = 2 * (RD + BC);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg7_scan2_if bus0 ();
    seg7_scan2_if bus1 ();
    logic [1:0] dbg0, dbg1;

    seg7_scan2 #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZB(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0)
    );
    seg7_scan2 #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZB(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // t = rising edges since reset release. The first frame entry is edge BC,
    // after which the frame repeats every FR cycles.
    int t;
    logic [3:0] mp0, mp1, mq0, mq1;
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    function automatic int phase();
        if (t < BC) return -1;
        return (t - BC) % FR;
    endfunction

    // Expected {frame, an1, an0, swg} after the current edge.
    function automatic logic [9:0] expect_out(input bit lzb);
        int ph;
        logic [9:0] e;
        ph = phase();
        e  = {1'b0, 1'b1, 1'b1, 7'h7F};
        if (ph >= 0 && ph < RD) begin
            e = {(ph == 0), 1'b1, 1'b0, seg_tab[mq0]};
        end else if (ph >= RD + BC && ph < 2 * RD + BC) begin
            if (!(lzb && mq1 == 4'd0)) e = {1'b0, 1'b0, 1'b1, seg_tab[mq1]};
        end
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input bit ld, input logic [3:0] d0, input logic [3:0] d1);
        bus0.load = ld; bus0.dig0 = d0; bus0.dig1 = d1;
        bus1.load = ld; bus1.dig0 = d0; bus1.dig1 = d1;
        @(posedge clk);
        t++;
        if (phase() == 0) begin
            mq0 = mp0;
            mq1 = mp1;
        end
        if (ld) begin
            mp0 = d0;
            mp1 = d1;
        end
        @(negedge clk);
        check("dut0_out", {22'b0, bus0.frame, bus0.an1, bus0.an0, bus0.swg}, {22'b0, expect_out(1'b0)});
        check("dut1_out", {22'b0, bus1.frame, bus1.an1, bus1.an0, bus1.swg}, {22'b0, expect_out(1'b1)});
        check("an_excl", {30'b0, ~bus0.an0 & ~bus0.an1, ~bus1.an0 & ~bus1.an1}, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endtask

    // Advance until the model sits at the given frame phase (bounded).
    task automatic run_to_phase(input int target);
        for (int i = 0; i < 2 * FR; i++) begin
            if (phase() == target) break;
            idle(1);
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_0"}, {22'b0, bus0.frame, bus0.an1, bus0.an0, bus0.swg}, {22'b0, 3'b011, 7'h7F});
        check({tag, "_1"}, {22'b0, bus1.frame, bus1.an1, bus1.an0, bus1.swg}, {22'b0, 3'b011, 7'h7F});
    endtask

    // Assert reset mid-cycle (called just after a negedge), hold across one
    // rising edge, release on the following falling edge.
    task automatic reset_dut(input string tag);
        #2 rst = 1'b1;
        #1 check_dark({tag, "_imm"});
        @(posedge clk);
        @(negedge clk);
        check_dark({tag, "_held"});
        rst = 1'b0;
        t = 0;
        mp0 = 4'd0; mp1 = 4'd0; mq0 = 4'd0; mq1 = 4'd0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus0.load = 1'b0; bus0.dig0 = 4'd0; bus0.dig1 = 4'd0;
        bus1.load = 1'b0; bus1.dig0 = 4'd0; bus1.dig1 = 4'd0;
        t = 0;
        mp0 = 4'd0; mp1 = 4'd0; mq0 = 4'd0; mq1 = 4'd0;

        @(negedge clk);
        reset_dut("reset");

        // Reset scan: zeros in both slots, frame every FR cycles.
        idle(2 * FR);

        // Load 4/7 during the tens slot; only visible from the next frame.
        run_to_phase(RD + BC + 1);
        step(1'b1, 4'd7, 4'd4);
        idle(2 * FR);

        // Leading zero: tens 0, ones 5.
        step(1'b1, 4'd5, 4'd0);
        idle(2 * FR);

        // Non-BCD ones digit shows a dash.
        step(1'b1, 4'd12, 4'd3);
        idle(FR + 2);

        // LOAD on the edge entering the ones slot: shown one frame later.
        run_to_phase(FR - 1);
        step(1'b1, 4'd9, 4'd8);
        idle(2 * FR + 2);

        // Reset mid tens slot with non-zero digits on display.
        step(1'b1, 4'd6, 4'd3);
        run_to_phase(FR - 1);
        idle(1);
        run_to_phase(RD + BC + 2);
        reset_dut("rst_mid");
        idle(2);
        check("an0_edge2", {31'b0, bus0.an0}, 32'd0);
        idle(FR);

        // Random loads, including back-to-back strobes, for 16 frames.
        for (int i = 0; i < 16 * FR; i++)
            step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
